// File: rtl/rmii_rx_framer.sv
// RMII receive framer.
// Takes the 2-bit RMII receive stream, strips the preamble and SFD, and assembles
// bytes LSB-dibit first. Each received byte comes out as a one-cycle strobe.
// At the end of every frame that reached DATA, it reports the length and these
// checks: CRC-32, alignment, PHY error and length.
module rmii_rx_framer #(
    parameter int MIN_PRE_DIBITS = 4,
    parameter int MIN_LEN        = 64,
    parameter int MAX_LEN        = 1522
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        frame_done,
    output logic [10:0] frame_len,
    output logic        frame_good,
    output logic        err_crc,
    output logic        err_align,
    output logic        err_phy,
    output logic        err_len
);

    localparam logic [1:0]  ST_IDLE     = 2'd0;
    localparam logic [1:0]  ST_PREAMBLE = 2'd1;
    localparam logic [1:0]  ST_DATA     = 2'd2;
    localparam logic [1:0]  ST_DROP     = 2'd3;

    localparam logic [1:0]  DIBIT_PRE   = 2'b01;
    localparam logic [1:0]  DIBIT_SFD   = 2'b11;

    localparam logic [3:0]  PRE_SAT     = 4'd15;
    localparam logic [3:0]  PRE_MIN     = 4'(MIN_PRE_DIBITS);
    localparam logic [10:0] LEN_SAT     = 11'd2047;
    localparam logic [10:0] LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX     = 11'(MAX_LEN);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
    // Residue of a good frame, expressed in the MSB-first bit order.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    // Fold one byte into the reflected CRC-32 register (LSB first, no final invert).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data_in);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Bit-reverse the 32-bit register.
    // The register is kept reflected, but the residue constant is MSB-first.
    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

    logic [1:0]  state_q,        state_d;
    logic [3:0]  pre_cnt_q,      pre_cnt_d;
    logic [1:0]  dib_cnt_q,      dib_cnt_d;
    logic [7:0]  byte_sr_q,      byte_sr_d;
    logic [10:0] byte_cnt_q,     byte_cnt_d;
    logic [31:0] crc_q,          crc_d;
    logic        phy_acc_q,      phy_acc_d;
    logic        len_acc_q,      len_acc_d;

    logic [7:0]  out_data_q,     out_data_d;
    logic        out_valid_q,    out_valid_d;
    logic        out_sof_q,      out_sof_d;
    logic        frame_done_q,   frame_done_d;
    logic [10:0] frame_len_q,    frame_len_d;
    logic        frame_good_q,   frame_good_d;
    logic        err_crc_q,      err_crc_d;
    logic        err_align_q,    err_align_d;
    logic        err_phy_q,      err_phy_d;
    logic        err_len_q,      err_len_d;

    logic [7:0]  byte_asm_s;
    logic        crc_bad_s;
    logic        align_bad_s;
    logic        phy_bad_s;
    logic        len_bad_s;

    // Compute the next-state, counter, CRC and output values from the current dibit.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        dib_cnt_d    = dib_cnt_q;
        byte_sr_d    = byte_sr_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        phy_acc_d    = phy_acc_q;
        len_acc_d    = len_acc_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        frame_good_d = frame_good_q;
        err_crc_d    = err_crc_q;
        err_align_d  = err_align_q;
        err_phy_d    = err_phy_q;
        err_len_d    = err_len_q;

        byte_asm_s   = {rx_d, byte_sr_q[7:2]};
        crc_bad_s    = (bit_rev32(crc_q) != CRC_RESIDUE);
        align_bad_s  = (dib_cnt_q != 2'd0);
        phy_bad_s    = phy_acc_q | rx_er;
        len_bad_s    = len_acc_q | (byte_cnt_q < LEN_MIN) | (byte_cnt_q > LEN_MAX);

        case (state_q)
            ST_IDLE: begin
                if (crs_dv && (rx_d == DIBIT_PRE)) begin
                    state_d   = ST_PREAMBLE;
                    pre_cnt_d = 4'd1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (!crs_dv) begin
                    state_d = ST_IDLE;
                end else if (rx_d == DIBIT_PRE) begin
                    if (pre_cnt_q != PRE_SAT) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        pre_cnt_d = pre_cnt_q;
                    end
                end else if ((rx_d == DIBIT_SFD) && (pre_cnt_q >= PRE_MIN)) begin
                    state_d    = ST_DATA;
                    crc_d      = CRC_INIT;
                    dib_cnt_d  = 2'd0;
                    byte_cnt_d = 11'd0;
                    phy_acc_d  = 1'b0;
                    len_acc_d  = 1'b0;
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                if (crs_dv) begin
                    byte_sr_d = byte_asm_s;
                    dib_cnt_d = dib_cnt_q + 2'd1;
                    if (rx_er) begin
                        phy_acc_d = 1'b1;
                    end else begin
                        phy_acc_d = phy_acc_q;
                    end
                    if (dib_cnt_q == 2'd3) begin
                        crc_d = crc32_byte(crc_q, byte_asm_s);
                        if (byte_cnt_q != LEN_SAT) begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end else begin
                            byte_cnt_d = byte_cnt_q;
                        end
                        // Once MAX_LEN bytes are out, further bytes are counted but suppressed.
                        if (byte_cnt_q >= LEN_MAX) begin
                            len_acc_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                            out_data_d  = byte_asm_s;
                            out_sof_d   = (byte_cnt_q == 11'd0);
                        end
                    end else begin
                        crc_d = crc_q;
                    end
                end else begin
                    // End of carrier: drop any partial byte and report the frame.
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_len_d  = byte_cnt_q;
                    err_crc_d    = crc_bad_s;
                    err_align_d  = align_bad_s;
                    err_phy_d    = phy_bad_s;
                    err_len_d    = len_bad_s;
                    frame_good_d = ~(crc_bad_s | align_bad_s | phy_bad_s | len_bad_s);
                end
            end

            ST_DROP: begin
                if (!crs_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all state and outputs; synchronous reset returns everything to idle.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= 4'd0;
            dib_cnt_q    <= 2'd0;
            byte_sr_q    <= 8'd0;
            byte_cnt_q   <= 11'd0;
            crc_q        <= CRC_INIT;
            phy_acc_q    <= 1'b0;
            len_acc_q    <= 1'b0;
            out_data_q   <= 8'd0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= 11'd0;
            frame_good_q <= 1'b0;
            err_crc_q    <= 1'b0;
            err_align_q  <= 1'b0;
            err_phy_q    <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            dib_cnt_q    <= dib_cnt_d;
            byte_sr_q    <= byte_sr_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            phy_acc_q    <= phy_acc_d;
            len_acc_q    <= len_acc_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            frame_good_q <= frame_good_d;
            err_crc_q    <= err_crc_d;
            err_align_q  <= err_align_d;
            err_phy_q    <= err_phy_d;
            err_len_q    <= err_len_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign frame_good = frame_good_q;
    assign err_crc    = err_crc_q;
    assign err_align  = err_align_q;
    assign err_phy    = err_phy_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Testbench for rmii_rx_framer.
// Directed frames are driven as RMII dibits. A frame-level model predicts the
// byte stream and the per-frame status. One compare process checks the DUT
// against that model on every falling clock edge.
module tb_rmii_rx_framer;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        crs_dv;
    logic [1:0]  rx_d;
    logic        rx_er;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sof;
    logic        frame_done;
    logic [10:0] frame_len;
    logic        frame_good;
    logic        err_crc;
    logic        err_align;
    logic        err_phy;
    logic        err_len;

    rmii_rx_framer dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .crs_dv     (crs_dv),
        .rx_d       (rx_d),
        .rx_er      (rx_er),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .frame_good (frame_good),
        .err_crc    (err_crc),
        .err_align  (err_align),
        .err_phy    (err_phy),
        .err_len    (err_len)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [10:0] len;
        logic        good;
        logic        crc;
        logic        align;
        logic        phy;
        logic        lenerr;
    } st_t;

    int          tests = 0;
    int          fails = 0;
    int          nvalid = 0;
    logic [7:0]  frm [0:2047];
    logic [8:0]  exp_q [$];
    st_t         st_q [$];
    st_t         hold_st;
    logic [7:0]  hold_data;
    logic        rst_smp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Standard Ethernet FCS of frm[0..cnt-1]: reflected CRC-32, final complement.
    function automatic logic [31:0] model_fcs(input int cnt);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    // Fill n bytes with a payload and a correct FCS, then optionally flip one bit.
    task automatic build_frame(input int n, input int seed, input int flip_bit);
        logic [31:0] fcs;
        for (int i = 0; i < n - 4; i++) begin
            frm[i] = 8'((i * 37 + seed * 101 + 5) & 255);
        end
        fcs = model_fcs(n - 4);
        frm[n-4] = fcs[7:0];
        frm[n-3] = fcs[15:8];
        frm[n-2] = fcs[23:16];
        frm[n-1] = fcs[31:24];
        if (flip_bit >= 0) begin
            frm[flip_bit / 8][flip_bit % 8] = ~frm[flip_bit / 8][flip_bit % 8];
        end
    endtask

    task automatic drive(input logic dv, input logic [1:0] d, input logic er);
        crs_dv = dv;
        rx_d   = d;
        rx_er  = er;
        @(posedge sys_clk);
        #1;
    endtask

    // Queue expectations for frm[0..n-1], then drive preamble, SFD, bytes, extra dibits and gap.
    task automatic send_frame(input int n, input int pre, input int extra,
                              input int er_byte, input int rst_byte, input int gap);
        st_t st;
        int  nb;
        bit  aborted;
        logic [31:0] got_fcs;
        nb = (rst_byte >= 0) ? rst_byte : n;
        for (int i = 0; i < nb && i < 1522; i++) begin
            exp_q.push_back({(i == 0), frm[i]});
        end
        if (rst_byte < 0) begin
            got_fcs   = {frm[n-1], frm[n-2], frm[n-3], frm[n-4]};
            st.len    = 11'((n > 2047) ? 2047 : n);
            st.crc    = (n < 4) ? 1'b1 : (model_fcs(n - 4) != got_fcs);
            st.align  = ((extra % 4) != 0);
            st.phy    = (er_byte >= 0) && (er_byte < n);
            st.lenerr = (n < 64) || (n > 1522);
            st.good   = !(st.crc || st.align || st.phy || st.lenerr);
            st_q.push_back(st);
        end
        for (int p = 0; p < pre; p++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        aborted = 1'b0;
        for (int i = 0; i < n && !aborted; i++) begin
            if (i == rst_byte) begin
                rst = 1'b1;
                drive(1'b1, frm[i][1:0], 1'b0);
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                for (int j = 0; j < 4; j++) begin
                    drive(1'b1, frm[i][2*j +: 2], (i == er_byte) && (j == 0));
                end
            end
        end
        for (int e = 0; e < extra && !aborted; e++) drive(1'b1, 2'b10, 1'b0);
        for (int g = 0; g < gap; g++) drive(1'b0, 2'b00, 1'b0);
    endtask

    // Track whether the most recent rising edge sampled reset.
    always @(posedge sys_clk) rst_smp <= rst;

    // Compare every cycle: bytes and status against the model, holds between strobes, zeros after reset.
    always @(negedge sys_clk) begin
        if (rst_smp) begin
            chk("reset_outputs", {5'd0, out_data, out_valid, out_sof, frame_done, frame_len,
                 frame_good, err_crc, err_align, err_phy, err_len}, 32'd0);
            hold_st   = '0;
            hold_data = 8'd0;
        end else begin
            if (out_valid) begin
                nvalid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    chk("byte", {23'd0, out_sof, out_data}, {23'd0, exp_q.pop_front()});
                end
                hold_data = out_data;
            end else begin
                chk("data_hold", {23'd0, out_sof, out_data}, {24'd0, hold_data});
            end
            if (frame_done) begin
                if (st_q.size() == 0) begin
                    chk("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    hold_st = st_q.pop_front();
                    chk("frame_status", {16'd0, frame_len, frame_good, err_crc, err_align, err_phy, err_len},
                        {16'd0, hold_st});
                end
            end else begin
                chk("status_hold", {16'd0, frame_len, frame_good, err_crc, err_align, err_phy, err_len},
                    {16'd0, hold_st});
            end
        end
    end

    initial begin
        rst    = 1'b1;
        crs_dv = 1'b0;
        rx_d   = 2'b00;
        rx_er  = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        rst = 1'b0;
        repeat (3) drive(1'b0, 2'b00, 1'b0);

        // Pin the FCS model with the standard check value of "123456789".
        for (int i = 0; i < 9; i++) frm[i] = 8'(8'h31 + i);
        chk("model_crc_check", model_fcs(9), 32'hCBF4_3926);

        // 1: good 64-byte frame.
        build_frame(64, 1, -1);
        nvalid = 0;
        send_frame(64, 8, 0, -1, -1, 3);
        chk("t1_nvalid", nvalid, 32'd64);
        chk("t1_len", {21'd0, frame_len}, 32'd64);
        chk("t1_flags", {27'd0, frame_good, err_crc, err_align, err_phy, err_len}, 32'b10000);

        // 2: one payload bit flipped.
        build_frame(64, 1, 100);
        send_frame(64, 8, 0, -1, -1, 3);
        chk("t2_flags", {27'd0, frame_good, err_crc, err_align, err_phy, err_len}, 32'b01000);
        chk("t2_len", {21'd0, frame_len}, 32'd64);

        // 3: two trailing dibits.
        build_frame(64, 2, -1);
        nvalid = 0;
        send_frame(64, 8, 2, -1, -1, 3);
        chk("t3_nvalid", nvalid, 32'd64);
        chk("t3_flags", {27'd0, frame_good, err_crc, err_align, err_phy, err_len}, 32'b00100);

        // 4: rx_er at byte 20.
        build_frame(64, 3, -1);
        nvalid = 0;
        send_frame(64, 8, 0, 20, -1, 3);
        chk("t4_nvalid", nvalid, 32'd64);
        chk("t4_flags", {27'd0, frame_good, err_crc, err_align, err_phy, err_len}, 32'b00010);

        // 5: bad preamble and early SFD are dropped; exactly MIN_PRE_DIBITS is accepted.
        nvalid = 0;
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 2'(i), 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 2'(i + 1), 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        chk("t5_no_bytes", nvalid, 32'd0);
        build_frame(64, 4, -1);
        send_frame(64, 4, 0, -1, -1, 3);
        chk("t5_min_pre_good", {31'd0, frame_good}, 32'd1);

        // 6: oversize frame, then a good frame after a 1-cycle gap.
        build_frame(1600, 5, -1);
        nvalid = 0;
        send_frame(1600, 8, 0, -1, -1, 1);
        chk("t6_nvalid", nvalid, 32'd1522);
        chk("t6_len", {21'd0, frame_len}, 32'd1600);
        chk("t6_err_len", {31'd0, err_len}, 32'd1);
        build_frame(64, 6, -1);
        nvalid = 0;
        send_frame(64, 8, 0, -1, -1, 3);
        chk("t6_next_nvalid", nvalid, 32'd64);
        chk("t6_next_good", {31'd0, frame_good}, 32'd1);

        // 7: reset at byte 30, then a good frame.
        build_frame(64, 7, -1);
        nvalid = 0;
        send_frame(64, 8, 0, -1, 30, 3);
        chk("t7_nvalid", nvalid, 32'd30);
        chk("t7_len_cleared", {21'd0, frame_len}, 32'd0);
        build_frame(64, 8, -1);
        send_frame(64, 8, 0, -1, -1, 3);
        chk("t7_next_good", {31'd0, frame_good}, 32'd1);
        chk("t7_next_len", {21'd0, frame_len}, 32'd64);

        repeat (5) drive(1'b0, 2'b00, 1'b0);
        chk("bytes_outstanding", exp_q.size(), 32'd0);
        chk("frames_outstanding", st_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
